// File: rtl/ps2_keys_pkg.sv
// Set-2 scancode constants, decoder state encoding, event record and ASCII map
// shared by the PS/2 key event queue.
package ps2_keys_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0, SC_E1 = 8'hE1, SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA, SC_FA = 8'hFA, SC_EE = 8'hEE, SC_FE = 8'hFE;
    localparam logic [7:0] SC_OVR_LO = 8'h00, SC_OVR_HI = 8'hFF;

    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;
    localparam logic [7:0] SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25, SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E, SC_9 = 8'h46;
    localparam logic [7:0] SC_SPACE = 8'h29, SC_ENTER = 8'h5A, SC_ESC = 8'h76;
    localparam logic [7:0] SC_UP = 8'h75, SC_LEFT = 8'h6B, SC_DOWN = 8'h72, SC_RIGHT = 8'h74;

    localparam int EV_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE_SKIP
    } dec_state_t;

    typedef struct packed {
        logic       mapped;
        logic       rel;
        logic       ext;
        logic [7:0] scan;
        logic [7:0] ascii;
    } key_event_t;

    // Returns {mapped, ascii}; unmapped codes give 9'h000.
    function automatic logic [8:0] map_ascii(input logic [7:0] scan, input logic ext);
        logic [8:0] r;
        r = 9'h000;
        if (ext) begin
            case (scan)
                SC_UP:    r = {1'b1, 8'h57};
                SC_LEFT:  r = {1'b1, 8'h41};
                SC_DOWN:  r = {1'b1, 8'h53};
                SC_RIGHT: r = {1'b1, 8'h44};
                default:  r = 9'h000;
            endcase
        end else begin
            case (scan)
                SC_A: r = {1'b1, 8'h41};  SC_B: r = {1'b1, 8'h42};  SC_C: r = {1'b1, 8'h43};
                SC_D: r = {1'b1, 8'h44};  SC_E: r = {1'b1, 8'h45};  SC_F: r = {1'b1, 8'h46};
                SC_G: r = {1'b1, 8'h47};  SC_H: r = {1'b1, 8'h48};  SC_I: r = {1'b1, 8'h49};
                SC_J: r = {1'b1, 8'h4A};  SC_K: r = {1'b1, 8'h4B};  SC_L: r = {1'b1, 8'h4C};
                SC_M: r = {1'b1, 8'h4D};  SC_N: r = {1'b1, 8'h4E};  SC_O: r = {1'b1, 8'h4F};
                SC_P: r = {1'b1, 8'h50};  SC_Q: r = {1'b1, 8'h51};  SC_R: r = {1'b1, 8'h52};
                SC_S: r = {1'b1, 8'h53};  SC_T: r = {1'b1, 8'h54};  SC_U: r = {1'b1, 8'h55};
                SC_V: r = {1'b1, 8'h56};  SC_W: r = {1'b1, 8'h57};  SC_X: r = {1'b1, 8'h58};
                SC_Y: r = {1'b1, 8'h59};  SC_Z: r = {1'b1, 8'h5A};
                SC_0: r = {1'b1, 8'h30};  SC_1: r = {1'b1, 8'h31};  SC_2: r = {1'b1, 8'h32};
                SC_3: r = {1'b1, 8'h33};  SC_4: r = {1'b1, 8'h34};  SC_5: r = {1'b1, 8'h35};
                SC_6: r = {1'b1, 8'h36};  SC_7: r = {1'b1, 8'h37};  SC_8: r = {1'b1, 8'h38};
                SC_9: r = {1'b1, 8'h39};
                SC_SPACE: r = {1'b1, 8'h20};
                SC_ENTER: r = {1'b1, 8'hFF};
                SC_ESC:   r = {1'b1, 8'h01};
                default:  r = 9'h000;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic first-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = cnt_q;
    // Head is forced to zero when empty so the outputs never show stale data.
    assign rdata   = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scancode decoder that turns the byte stream into make/break key
// events, tracks the held key and queues events behind a valid/ready FIFO.
//   state         | meaning
//   ST_IDLE       | waiting for a code or prefix
//   ST_EXT        | E0 seen
//   ST_BRK        | F0 seen
//   ST_EXT_BRK    | E0 F0 seen
//   ST_PAUSE_SKIP | swallowing the rest of the E1 pause sequence
module ps2_key_event_queue
    import ps2_keys_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter bit REPORT_RELEASE = 1'b1,
    parameter bit TYPEMATIC_FILT = 1'b1,
    parameter bit EMIT_UNMAPPED  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [7:0]                    ev_ascii,
    output logic [7:0]                    ev_scan,
    output logic                          ev_extended,
    output logic                          ev_release,
    output logic                          ev_mapped,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          held_valid,
    output logic [7:0]                    held_ascii
);
    dec_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       held_valid_q, held_valid_d, held_ext_q, held_ext_d;
    logic [7:0] held_scan_q, held_scan_d, held_ascii_q, held_ascii_d;
    logic       overflow_q, overflow_d;

    logic       is_ev, ev_rel, ev_ext, held_match, ev_push;
    logic [8:0] map;
    key_event_t ev_in, ev_head;
    logic       fifo_full, fifo_empty, fifo_pop;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_scan_d  = held_scan_q;
        held_ascii_d = held_ascii_q;
        is_ev        = 1'b0;
        ev_rel       = 1'b0;
        ev_ext       = 1'b0;
        ev_push      = 1'b0;
        if (rx_valid) begin
            if (rx_data == SC_OVR_LO || rx_data == SC_OVR_HI) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        case (rx_data)
                            SC_E0: state_d = ST_EXT;
                            SC_F0: state_d = ST_BRK;
                            SC_E1: begin
                                state_d = ST_PAUSE_SKIP;
                                cnt_d   = 3'd7;
                            end
                            SC_AA, SC_FA, SC_EE, SC_FE: state_d = ST_IDLE;
                            default: is_ev = 1'b1;
                        endcase
                    end
                    ST_EXT: begin
                        if (rx_data == SC_F0) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            is_ev   = 1'b1;
                            ev_ext  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        is_ev   = 1'b1;
                        ev_rel  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        is_ev   = 1'b1;
                        ev_rel  = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    ST_PAUSE_SKIP: begin
                        if (cnt_q == 3'd1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        map        = map_ascii(rx_data, ev_ext);
        held_match = held_valid_q && (held_scan_q == rx_data) && (held_ext_q == ev_ext);
        if (is_ev) begin
            if (ev_rel) begin
                if (held_match) held_valid_d = 1'b0;
                ev_push = REPORT_RELEASE && (map[8] || EMIT_UNMAPPED);
            end else begin
                ev_push      = !(TYPEMATIC_FILT && held_match) && (map[8] || EMIT_UNMAPPED);
                held_valid_d = 1'b1;
                held_scan_d  = rx_data;
                held_ext_d   = ev_ext;
                held_ascii_d = map[7:0];
            end
        end
        ev_in = '{mapped: map[8], rel: ev_rel, ext: ev_ext, scan: rx_data, ascii: map[7:0]};

        // Set takes priority over a same-cycle clear.
        overflow_d = overflow_q && !overflow_clr;
        if (ev_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_scan_q  <= '0;
            held_ascii_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_scan_q  <= held_scan_d;
            held_ascii_q <= held_ascii_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fifo_pop = ev_valid && ev_ready;

    ps2_event_fifo #(.WIDTH(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev_push),
        .wdata (ev_in),
        .pop   (fifo_pop),
        .rdata (ev_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (ev_count)
    );

    assign ev_valid    = !fifo_empty;
    assign ev_ascii    = ev_head.ascii;
    assign ev_scan     = ev_head.scan;
    assign ev_extended = ev_head.ext;
    assign ev_release  = ev_head.rel;
    assign ev_mapped   = ev_head.mapped;
    assign overflow    = overflow_q;
    assign held_valid  = held_valid_q;
    assign held_ascii  = held_ascii_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench: two queue instances (default build and a variant with
// releases hidden, no typematic filter and unmapped codes emitted) share stimulus.
module tb_ps2_key_event_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ev_ready = 1'b1;
    logic       overflow_clr = 1'b0;

    logic       ev_valid_a, ev_extended_a, ev_release_a, ev_mapped_a, overflow_a, held_valid_a;
    logic [7:0] ev_ascii_a, ev_scan_a, held_ascii_a;
    logic [3:0] ev_count_a;
    logic       ev_valid_b, ev_extended_b, ev_release_b, ev_mapped_b, overflow_b, held_valid_b;
    logic [7:0] ev_ascii_b, ev_scan_b, held_ascii_b;
    logic [3:0] ev_count_b;

    int n_total = 0;
    int n_bad = 0;
    logic [18:0] qa[$];
    logic [18:0] qb[$];

    always #5 clk = ~clk;

    ps2_key_event_queue dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .ev_ready(ev_ready),
        .ev_valid(ev_valid_a), .ev_ascii(ev_ascii_a), .ev_scan(ev_scan_a),
        .ev_extended(ev_extended_a), .ev_release(ev_release_a), .ev_mapped(ev_mapped_a),
        .ev_count(ev_count_a), .overflow(overflow_a), .overflow_clr(overflow_clr),
        .held_valid(held_valid_a), .held_ascii(held_ascii_a)
    );

    ps2_key_event_queue #(.FIFO_DEPTH(8), .REPORT_RELEASE(1'b0), .TYPEMATIC_FILT(1'b0),
                          .EMIT_UNMAPPED(1'b1)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .ev_ready(ev_ready),
        .ev_valid(ev_valid_b), .ev_ascii(ev_ascii_b), .ev_scan(ev_scan_b),
        .ev_extended(ev_extended_b), .ev_release(ev_release_b), .ev_mapped(ev_mapped_b),
        .ev_count(ev_count_b), .overflow(overflow_b), .overflow_clr(overflow_clr),
        .held_valid(held_valid_b), .held_ascii(held_ascii_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ev(input logic m, input logic r, input logic e,
                                       input logic [7:0] s, input logic [7:0] a);
        return {m, r, e, s, a};
    endfunction

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        chk("count_a_empty", ev_count_a, 0);
    endtask

    always @(negedge clk) begin
        if (reset && ev_valid_a && ev_ready) begin
            if (qa.size() == 0) chk("spurious_a", ev_valid_a, 0);
            else chk("event_a", {ev_mapped_a, ev_release_a, ev_extended_a, ev_scan_a, ev_ascii_a},
                     qa.pop_front());
        end
        if (reset && ev_valid_b && ev_ready) begin
            if (qb.size() == 0) chk("spurious_b", ev_valid_b, 0);
            else chk("event_b", {ev_mapped_b, ev_release_b, ev_extended_b, ev_scan_b, ev_ascii_b},
                     qb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] keys [9];
        logic [7:0] ascs [9];
        keys = '{8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
        ascs = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ev_valid_a, 0);
        chk("rst_count", ev_count_a, 0);
        chk("rst_ovf", overflow_a, 0);
        chk("rst_held", held_valid_a, 0);
        chk("rst_ascii", ev_ascii_a, 0);
        reset = 1'b1;

        // plain make and break
        qa.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        qb.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        send(8'h1C);
        chk("held_a_make", held_valid_a, 1);
        chk("held_ascii_a", held_ascii_a, 8'h41);
        qa.push_back(ev(1, 1, 0, 8'h1C, 8'h41));
        send(8'hF0); send(8'h1C);
        chk("held_a_break", held_valid_a, 0);
        drain();

        // extended up arrow
        qa.push_back(ev(1, 0, 1, 8'h75, 8'h57));
        qb.push_back(ev(1, 0, 1, 8'h75, 8'h57));
        send(8'hE0); send(8'h75);
        chk("held_ext_make", held_valid_a, 1);
        qa.push_back(ev(1, 1, 1, 8'h75, 8'h57));
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("held_ext_break", held_valid_a, 0);
        chk("held_ext_break_b", held_valid_b, 0);
        drain();

        // typematic repeats
        qa.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        qa.push_back(ev(1, 1, 0, 8'h1C, 8'h41));
        repeat (3) qb.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain();

        // pause sequence then space
        qa.push_back(ev(1, 0, 0, 8'h29, 8'h20));
        qb.push_back(ev(1, 0, 0, 8'h29, 8'h20));
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29);
        drain();

        // unmapped code, ACK byte, overrun inside an extended prefix
        qb.push_back(ev(0, 0, 0, 8'h0E, 8'h00));
        send(8'h0E);
        send(8'hFA);
        qa.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        qb.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        send(8'hE0); send(8'h00); send(8'h1C);
        drain();

        // fill with ready low; ninth event is dropped
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                qa.push_back(ev(1, 0, 0, keys[i], ascs[i]));
                qb.push_back(ev(1, 0, 0, keys[i], ascs[i]));
            end
            send(keys[i]);
        end
        chk("full_count_a", ev_count_a, 8);
        chk("full_count_b", ev_count_b, 8);
        chk("ovf_a", overflow_a, 1);
        chk("ovf_b", overflow_b, 1);
        chk("head_intact", ev_ascii_a, 8'h42);

        // push while full with a same-cycle pop is accepted
        @(posedge clk); #1;
        qa.push_back(ev(1, 0, 0, 8'h42, 8'h4B));
        qb.push_back(ev(1, 0, 0, 8'h42, 8'h4B));
        rx_data = 8'h42; rx_valid = 1'b1; ev_ready = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; ev_ready = 1'b0;
        chk("swap_count", ev_count_a, 8);
        chk("swap_head", ev_ascii_a, 8'h43);
        @(posedge clk); #1;
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow_a, 0);
        ev_ready = 1'b1;
        drain();

        // async reset mid-sequence
        send(8'hE0); send(8'hF0);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("rst_mid_held", held_valid_a, 0);
        chk("rst_mid_valid", ev_valid_a, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        qa.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        qb.push_back(ev(1, 0, 0, 8'h1C, 8'h41));
        send(8'h1C);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
